// File: rtl/riscv_structures.sv
// Shared pipeline records, funct3 codes and memory-stage state types.
// Also holds the small access-size decode helpers used by the memory stage.
package riscv_structures;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_funct3;
    logic        reg_write;
    logic [4:0]  rd;
    logic        is_final;
  } ex_to_mem_s;

  typedef struct packed {
    logic [31:0] data;
    logic        reg_write;
    logic [4:0]  rd;
    logic        is_final;
    logic        misalign;
  } mem_to_wb_s;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // What a load needs to remember while the RAM read is in flight.
  typedef struct packed {
    logic [1:0] lane;
    logic [2:0] funct3;
    logic       reg_write;
    logic [4:0] rd;
    logic       is_final;
  } ld_req_s;

  // Unsigned sub-word codes only exist for loads; everything unknown is a word.
  function automatic acc_size_e access_size(input logic [2:0] f3, input logic is_store);
    if (f3 == F3_B || (!is_store && f3 == F3_BU)) return SZ_BYTE;
    if (f3 == F3_H || (!is_store && f3 == F3_HU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_HALF: return lane[0];
      SZ_WORD: return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ext_byte_en_ram.sv
// Word-organised data RAM with per-byte write enables and a fixed-depth read pipeline.
// The last read stage holds its value until a newer read reaches it, so a stalled consumer never loses data.
module byte_en_ram #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int LOAD_LATENCY = 2,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  localparam int ADV_W = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 1 : 1;

  logic [31:0]      mem  [DEPTH_WORDS];
  logic [31:0]      pipe [LOAD_LATENCY];
  logic [ADV_W-1:0] adv;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // adv[i] marks that pipe[i] took fresh data on the last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adv <= '0;
    end else begin
      adv[0] <= re;
      for (int i = 1; i < LOAD_LATENCY - 1; i++) adv[i] <= adv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (re) pipe[0] <= mem[raddr];
    for (int i = 1; i < LOAD_LATENCY; i++) begin
      if (adv[i-1]) pipe[i] <= pipe[i-1];
    end
  end

  assign rdata = pipe[LOAD_LATENCY-1];

endmodule

// File: rtl/mem_stage_ext.sv
// Pipeline memory stage: sub-word loads/stores, misalignment trapping and a wait-state
// FSM in front of a fixed-latency data RAM, with valid/ready on both sides.
module mem_stage_ext
  import riscv_structures::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int LOAD_LATENCY = 2,
  parameter int DEBUG_PRINT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  ex_to_mem_s ex_to_mem,
  output logic       out_valid,
  input  logic       out_ready,
  output mem_to_wb_s mem_to_wb,
  output mem_state_e fsm_state
);

  // Handshake: a transfer happens on any edge where valid && ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LOAD_LATENCY - 1);

  mem_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  ld_req_s          req_q, req_n;
  logic             cap;
  logic             wb_load;
  mem_to_wb_s       wb_n;

  logic             slot_free, accept;
  logic             is_store, is_load, misalign_in;
  logic [1:0]       lane_in;
  acc_size_e        in_size, ld_size;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      wdata;
  logic [3:0]       be;
  logic             ram_we, ram_re;
  logic [31:0]      rdata;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic             ld_signed;
  logic [31:0]      ld_data;

  assign slot_free   = !out_valid || out_ready;
  assign in_ready    = (state == ST_IDLE) && slot_free;
  assign accept      = in_valid && in_ready;
  assign fsm_state   = state;

  // A request with both mem_read and mem_write set is a store.
  assign is_store    = ex_to_mem.mem_write;
  assign is_load     = ex_to_mem.mem_read && !ex_to_mem.mem_write;
  assign lane_in     = ex_to_mem.alu_result[1:0];
  assign word_idx    = ex_to_mem.alu_result[IDX_W+1:2];
  assign in_size     = access_size(ex_to_mem.mem_funct3, is_store);
  assign misalign_in = (is_store || is_load) && is_misaligned(in_size, lane_in);

  assign ram_we = accept && is_store && !misalign_in;
  assign ram_re = accept && is_load && !misalign_in;

  always_comb begin
    wdata = ex_to_mem.mem_data;
    be    = 4'b1111;
    case (in_size)
      SZ_BYTE: begin
        wdata = {4{ex_to_mem.mem_data[7:0]}};
        be    = 4'b0001 << lane_in;
      end
      SZ_HALF: begin
        wdata = {2{ex_to_mem.mem_data[15:0]}};
        be    = lane_in[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  byte_en_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LOAD_LATENCY(LOAD_LATENCY)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .be   (be),
    .waddr(word_idx),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(word_idx),
    .rdata(rdata)
  );

  // Lane selection and extension use the captured request, not the live input.
  assign ld_size   = access_size(req_q.funct3, 1'b0);
  assign ld_signed = (req_q.funct3 == F3_B) || (req_q.funct3 == F3_H);
  assign sel_byte  = rdata[8*req_q.lane +: 8];
  assign sel_half  = req_q.lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ld_data = rdata;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & sel_byte[7]}}, sel_byte};
      SZ_HALF: ld_data = {{16{ld_signed & sel_half[15]}}, sel_half};
      default: ;
    endcase
  end

  always_comb begin
    req_n.lane      = lane_in;
    req_n.funct3    = ex_to_mem.mem_funct3;
    req_n.reg_write = ex_to_mem.reg_write;
    req_n.rd        = ex_to_mem.rd;
    req_n.is_final  = ex_to_mem.is_final;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    wb_load = 1'b0;
    wb_n    = mem_to_wb;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          wb_n.data      = ex_to_mem.alu_result;
          wb_n.reg_write = ex_to_mem.reg_write;
          wb_n.rd        = ex_to_mem.rd;
          wb_n.is_final  = ex_to_mem.is_final;
          wb_n.misalign  = 1'b0;
          if (misalign_in) begin
            wb_load        = 1'b1;
            wb_n.reg_write = 1'b0;
            wb_n.misalign  = 1'b1;
          end else if (is_load) begin
            state_n = ST_WAIT;
            cnt_n   = CNT_START;
            cap     = 1'b1;
          end else begin
            wb_load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (slot_free) begin
          wb_load        = 1'b1;
          wb_n.data      = ld_data;
          wb_n.reg_write = req_q.reg_write;
          wb_n.rd        = req_q.rd;
          wb_n.is_final  = req_q.is_final;
          wb_n.misalign  = 1'b0;
          state_n        = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      out_valid <= 1'b0;
      mem_to_wb <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (cap) req_q <= req_n;
      if (wb_load) begin
        mem_to_wb <= wb_n;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ext.sv
// Self-checking bench for mem_stage_ext: directed scenarios plus randomized traffic
// compared against a byte-addressed reference memory and an expected-result queue.
module tb_mem_stage_ext;
  import riscv_structures::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;
  localparam int MW    = $bits(mem_to_wb_s);

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  ex_to_mem_s ex_to_mem;
  logic       out_valid;
  logic       out_ready;
  mem_to_wb_s mem_to_wb;
  mem_state_e fsm_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    mm [BYTES];
  logic [MW-1:0] exp_q [$];

  mem_stage_ext #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .LOAD_LATENCY(LAT),
    .DEBUG_PRINT (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ex_to_mem(ex_to_mem),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mem_to_wb(mem_to_wb),
    .fsm_state(fsm_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ex_to_mem_s mk(input logic [31:0] a, input logic [31:0] d,
                                    input logic rd_en, input logic wr_en,
                                    input logic [2:0] f3, input logic [4:0] rdi);
    ex_to_mem_s p;
    p.alu_result = a;
    p.mem_data   = d;
    p.mem_read   = rd_en;
    p.mem_write  = wr_en;
    p.mem_funct3 = f3;
    p.reg_write  = !wr_en;
    p.rd         = rdi;
    p.is_final   = 1'b0;
    return p;
  endfunction

  function automatic logic [31:0] model_word(input int unsigned a);
    int unsigned b;
    b = (a % BYTES) & ~32'h3;
    return {mm[b+3], mm[b+2], mm[b+1], mm[b]};
  endfunction

  // Reference: byte-addressed little-endian memory, results in acceptance order.
  task automatic model_push(input ex_to_mem_s p);
    mem_to_wb_s  r;
    int unsigned a;
    int          nb;
    bit          st, ld, sgn;
    longint      v;
    a  = p.alu_result % BYTES;
    st = p.mem_write;
    ld = p.mem_read && !p.mem_write;
    r.data      = p.alu_result;
    r.reg_write = p.reg_write;
    r.rd        = p.rd;
    r.is_final  = p.is_final;
    r.misalign  = 1'b0;
    if (st || ld) begin
      if (p.mem_funct3 == 3'b000 || (ld && p.mem_funct3 == 3'b100)) nb = 1;
      else if (p.mem_funct3 == 3'b001 || (ld && p.mem_funct3 == 3'b101)) nb = 2;
      else nb = 4;
      if (a % nb != 0) begin
        r.misalign  = 1'b1;
        r.reg_write = 1'b0;
      end else if (st) begin
        for (int i = 0; i < nb; i++) mm[a+i] = p.mem_data[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < nb; i++) v += longint'(mm[a+i]) << (8*i);
        sgn = (p.mem_funct3 == 3'b000) || (p.mem_funct3 == 3'b001);
        if (sgn && nb < 4 && v >= (longint'(1) << (8*nb - 1))) v -= (longint'(1) << (8*nb));
        r.data = v[31:0];
      end
    end
    exp_q.push_back(r);
  endtask

  // Driver: entered at a falling edge, returns at the falling edge after acceptance.
  task automatic send(input ex_to_mem_s p, input bit rand_ready);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    ex_to_mem = p;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(waited), 64'd0);
    end else begin
      model_push(p);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // n counts edges from the accepting edge (inclusive) to the one that raised out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    #1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  // Scoreboard: every output transfer is checked against the head of exp_q.
  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL wb_unexpected: observed %h expected none", mem_to_wb);
        end
      end else begin
        chk("wb_record", mem_to_wb, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: observed time %0t expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int c0;
    int unsigned a;
    ex_to_mem_s p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ex_to_mem = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_to_wb", mem_to_wb, '0);
    chk("rst_state", fsm_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Preload every word so later loads compare against known contents.
    for (int w = 0; w < DEPTH; w++) send(mk(32'(w * 4), $urandom, 1'b0, 1'b1, F3_W, 5'd0), 1'b0);

    // Store word then load it back; out_valid on the 3rd edge counting the accept edge.
    send(mk(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, F3_W, 5'd0), 1'b0);
    send(mk(32'h10, 32'h0, 1'b1, 1'b0, F3_W, 5'd7), 1'b0);
    wait_valid(n);
    chk("lw_latency", 64'(n), 64'(LAT + 1));
    chk("lw_data", mem_to_wb.data, 32'hDEADBEEF);
    chk("lw_rd", mem_to_wb.rd, 5'd7);
    chk("lw_reg_write", mem_to_wb.reg_write, 1'b1);

    // Sub-word loads
    @(negedge clk);
    send(mk(32'h21, 32'h80, 1'b0, 1'b1, F3_B, 5'd0), 1'b0);
    send(mk(32'h21, 32'h0, 1'b1, 1'b0, F3_B, 5'd3), 1'b0);
    wait_valid(n);
    chk("lb_data", mem_to_wb.data, 32'hFFFFFF80);
    @(negedge clk);
    send(mk(32'h21, 32'h0, 1'b1, 1'b0, F3_BU, 5'd4), 1'b0);
    wait_valid(n);
    chk("lbu_data", mem_to_wb.data, 32'h00000080);
    @(negedge clk);
    send(mk(32'h20, 32'h80000000, 1'b0, 1'b1, F3_W, 5'd0), 1'b0);
    send(mk(32'h22, 32'h0, 1'b1, 1'b0, F3_H, 5'd5), 1'b0);
    wait_valid(n);
    chk("lh_hi_data", mem_to_wb.data, 32'hFFFF8000);
    @(negedge clk);
    send(mk(32'h22, 32'h0, 1'b1, 1'b0, F3_HU, 5'd5), 1'b0);
    wait_valid(n);
    chk("lhu_hi_data", mem_to_wb.data, 32'h00008000);
    @(negedge clk);
    send(mk(32'h20, 32'h0, 1'b1, 1'b0, F3_H, 5'd6), 1'b0);
    wait_valid(n);
    chk("lh_lo_data", mem_to_wb.data, 32'h00000000);

    // Misaligned accesses
    @(negedge clk);
    send(mk(32'h13, 32'h0, 1'b1, 1'b0, F3_W, 5'd8), 1'b0);
    wait_valid(n);
    chk("mis_lw_latency", 64'(n), 64'd1);
    chk("mis_lw_flag", mem_to_wb.misalign, 1'b1);
    chk("mis_lw_reg_write", mem_to_wb.reg_write, 1'b0);
    chk("mis_lw_data", mem_to_wb.data, 32'h13);
    @(negedge clk);
    send(mk(32'h15, 32'hABCD, 1'b0, 1'b1, F3_H, 5'd0), 1'b0);
    wait_valid(n);
    chk("mis_sh_flag", mem_to_wb.misalign, 1'b1);
    @(negedge clk);
    send(mk(32'h14, 32'h0, 1'b1, 1'b0, F3_W, 5'd9), 1'b0);
    wait_valid(n);
    chk("mis_sh_unchanged", mem_to_wb.data, model_word(32'h14));

    // Backpressure: result held stable, no new accept until the transfer.
    @(negedge clk);
    out_ready = 1'b0;
    send(mk(32'h12345678, 32'h0, 1'b0, 1'b0, F3_W, 5'd9), 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_hold", mem_to_wb, exp_q[0]);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    @(negedge clk);
    #1;
    chk("bp_after_valid", out_valid, 1'b0);
    chk("bp_after_ready", in_ready, 1'b1);
    @(negedge clk);

    // Address wrap: 0x1000 aliases 0x0000.
    send(mk(32'h1000, 32'hCAFEF00D, 1'b0, 1'b1, F3_W, 5'd0), 1'b0);
    send(mk(32'h0000, 32'h0, 1'b1, 1'b0, F3_W, 5'd10), 1'b0);
    wait_valid(n);
    chk("wrap_data", mem_to_wb.data, 32'hCAFEF00D);
    @(negedge clk);

    // Throughput: back-to-back ALU ops, one per cycle.
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(mk($urandom, $urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 5'(i)), 1'b0);
      chk("b2b_out_valid", out_valid, 1'b1);
    end
    chk("b2b_cycles", 64'(cyc - c0), 64'd8);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 2 * BYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      if ($urandom_range(0, 1) != 0) a = a | 32'h8000_0000;
      case ($urandom_range(0, 3))
        0:       p = mk(a, $urandom, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 5'($urandom));
        1:       p = mk(a, $urandom, 1'b0, 1'b1, 3'($urandom_range(0, 7)), 5'($urandom));
        default: p = mk(a, $urandom, 1'b1, ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)), 5'($urandom));
      endcase
      p.reg_write = 1'($urandom);
      p.is_final  = 1'($urandom);
      send(p, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Reset while a load is waiting aborts it.
    send(mk(32'h10, 32'h0, 1'b1, 1'b0, F3_W, 5'd11), 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_mem_to_wb", mem_to_wb, '0);
    chk("midrst_state", fsm_state, ST_IDLE);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_output", out_valid, 1'b0);
    end
    @(negedge clk);
    send(mk(32'h55AA, 32'h0, 1'b0, 1'b0, F3_W, 5'd12), 1'b0);
    wait_valid(n);
    chk("post_rst_alu", mem_to_wb.data, 32'h55AA);
    @(negedge clk);
    send(mk(32'h10, 32'h0, 1'b1, 1'b0, F3_W, 5'd13), 1'b0);
    wait_valid(n);
    chk("post_rst_lw_latency", 64'(n), 64'(LAT + 1));
    chk("post_rst_lw_data", mem_to_wb.data, model_word(32'h10));
    repeat (3) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
